// File: rtl/hero_sprite_indexer_pkg.sv
// Shared defaults and types for the running-hero sprite indexer.
package hero_sprite_pkg;

  localparam int DEF_SPR_W      = 32;
  localparam int DEF_SPR_H      = 48;
  localparam int DEF_FRAMES     = 4;
  localparam int DEF_FRAME_HOLD = 6;
  localparam int DEF_ADDR_W     = 13;

  // Palette index 0 is the green chroma key.
  localparam logic [2:0] TRANSPARENT_IDX = 3'd0;

  // Pixel coordinate relative to the hero's top-left corner.
  typedef logic signed [10:0] rel_coord_t;

  function automatic int width_of(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/hero_anim_ctr.sv
// Running-animation sequencer: each animation frame is held for FRAME_HOLD video frames.
module hero_anim_ctr
  import hero_sprite_pkg::*;
#(
  parameter int FRAMES     = DEF_FRAMES,
  parameter int FRAME_HOLD = DEF_FRAME_HOLD,
  parameter int FRAME_W    = width_of(DEF_FRAMES)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               frame_start,
  input  logic               running,
  output logic [FRAME_W-1:0] frame
);

  localparam int HOLD_W = width_of(FRAME_HOLD);

  logic [HOLD_W-1:0] hold;

  // Standing pose snaps back to frame 0 on the next vertical blank.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold  <= '0;
      frame <= '0;
    end else if (frame_start) begin
      if (!running) begin
        hold  <= '0;
        frame <= '0;
      end else if (hold == HOLD_W'(FRAME_HOLD - 1)) begin
        hold  <= '0;
        frame <= (frame == FRAME_W'(FRAMES - 1)) ? '0 : frame + 1'b1;
      end else begin
        hold <= hold + 1'b1;
      end
    end
  end

endmodule

// File: rtl/hero_sprite_indexer.sv
// Per-pixel hero sprite lookup: bounding-box test, ROM addressing with mirroring,
// and a 3-stage pipeline (address, external ROM, output) to the palette stage.
module hero_sprite_indexer
  import hero_sprite_pkg::*;
#(
  parameter int SPR_W      = DEF_SPR_W,
  parameter int SPR_H      = DEF_SPR_H,
  parameter int FRAMES     = DEF_FRAMES,
  parameter int FRAME_HOLD = DEF_FRAME_HOLD,
  parameter int ADDR_W     = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              frame_start,
  input  logic              pix_valid,
  input  logic [9:0]        draw_x,
  input  logic [9:0]        draw_y,
  input  logic [9:0]        hero_x,
  input  logic [9:0]        hero_y,
  input  logic              running,
  input  logic              facing_left,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [2:0]        rom_data,
  output logic              out_valid,
  output logic [2:0]        out_index,
  output logic              out_opaque
);

  localparam int FRAME_W = width_of(FRAMES);

  logic [9:0]         hx_l;
  logic [9:0]         hy_l;
  logic               facing_l;
  logic [FRAME_W-1:0] frame;
  rel_coord_t         rel_x;
  rel_coord_t         rel_y;
  logic               inbox;
  logic [9:0]         col;
  logic [31:0]        addr_full;
  logic               valid_q;
  logic               inbox_q;
  logic               valid_q2;
  logic               inbox_q2;

  hero_anim_ctr #(
    .FRAMES     (FRAMES),
    .FRAME_HOLD (FRAME_HOLD),
    .FRAME_W    (FRAME_W)
  ) u_anim (
    .clk         (clk),
    .rst_n       (rst_n),
    .frame_start (frame_start),
    .running     (running),
    .frame       (frame)
  );

  // Position and facing only change at vertical blank so a frame never tears.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hx_l     <= '0;
      hy_l     <= '0;
      facing_l <= 1'b0;
    end else if (frame_start) begin
      hx_l     <= hero_x;
      hy_l     <= hero_y;
      facing_l <= facing_left;
    end
  end

  assign rel_x = $signed({1'b0, draw_x}) - $signed({1'b0, hx_l});
  assign rel_y = $signed({1'b0, draw_y}) - $signed({1'b0, hy_l});

  assign inbox = !rel_x[10] && (rel_x[9:0] < 10'(SPR_W)) &&
                 !rel_y[10] && (rel_y[9:0] < 10'(SPR_H));

  assign col = facing_l ? (10'(SPR_W - 1) - rel_x[9:0]) : rel_x[9:0];

  assign addr_full = 32'(frame) * 32'(SPR_W * SPR_H)
                   + 32'(rel_y[9:0]) * 32'(SPR_W)
                   + 32'(col);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rom_addr <= '0;
      valid_q  <= 1'b0;
      inbox_q  <= 1'b0;
      valid_q2 <= 1'b0;
      inbox_q2 <= 1'b0;
    end else begin
      rom_addr <= inbox ? addr_full[ADDR_W-1:0] : '0;
      valid_q  <= pix_valid;
      inbox_q  <= inbox;
      valid_q2 <= valid_q;
      inbox_q2 <= inbox_q;
    end
  end

  // rom_data now holds the word for the pixel in stage 2.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_index  <= TRANSPARENT_IDX;
      out_opaque <= 1'b0;
    end else begin
      out_valid  <= valid_q2;
      out_index  <= (valid_q2 && inbox_q2) ? rom_data : TRANSPARENT_IDX;
      out_opaque <= valid_q2 && inbox_q2 && (rom_data != TRANSPARENT_IDX);
    end
  end

endmodule

// File: tb/tb_hero_sprite_indexer.sv
// Directed scoreboard bench for hero_sprite_indexer with a behavioural sprite ROM.
module tb_hero_sprite_indexer;

  localparam int SPR_W      = 32;
  localparam int SPR_H      = 48;
  localparam int FRAMES     = 4;
  localparam int FRAME_HOLD = 6;
  localparam int ADDR_W     = 13;

  typedef struct {
    int         cyc;
    logic [2:0] idx;
    logic       opq;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              frame_start;
  logic              pix_valid;
  logic [9:0]        draw_x;
  logic [9:0]        draw_y;
  logic [9:0]        hero_x;
  logic [9:0]        hero_y;
  logic              running;
  logic              facing_left;
  logic [ADDR_W-1:0] rom_addr;
  logic [2:0]        rom_data = 3'd0;
  logic              out_valid;
  logic [2:0]        out_index;
  logic              out_opaque;

  exp_t              sb[$];
  int                nvec = 0;
  int                nfail = 0;
  int                cyc = 0;
  logic              pend_valid = 1'b0;
  logic [ADDR_W-1:0] pend_addr = '0;
  int                m_hx = 0;
  int                m_hy = 0;
  logic              m_facing = 1'b0;
  int                m_hold = 0;
  int                m_frame = 0;

  hero_sprite_indexer #(
    .SPR_W      (SPR_W),
    .SPR_H      (SPR_H),
    .FRAMES     (FRAMES),
    .FRAME_HOLD (FRAME_HOLD),
    .ADDR_W     (ADDR_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .frame_start (frame_start),
    .pix_valid   (pix_valid),
    .draw_x      (draw_x),
    .draw_y      (draw_y),
    .hero_x      (hero_x),
    .hero_y      (hero_y),
    .running     (running),
    .facing_left (facing_left),
    .rom_addr    (rom_addr),
    .rom_data    (rom_data),
    .out_valid   (out_valid),
    .out_index   (out_index),
    .out_opaque  (out_opaque)
  );

  always #5 clk = ~clk;

  function automatic logic [2:0] rom_fn(input logic [ADDR_W-1:0] a);
    return a[2:0] ^ a[5:3] ^ a[8:6] ^ a[11:9] ^ {2'b00, a[12]};
  endfunction

  // Synchronous sprite ROM with one cycle of read latency.
  always @(posedge clk) rom_data <= rom_fn(rom_addr);

  task automatic checkOutput();
    exp_t e;
    if (pend_valid) begin
      nvec++;
      assert (rom_addr === pend_addr) else begin
        nfail++;
        $error("[TB] FAIL rom_addr cyc=%0d observed=%0d expected=%0d", cyc, rom_addr, pend_addr);
      end
    end
    if (out_valid === 1'b1) begin
      nvec++;
      assert (sb.size() != 0) else begin
        nfail++;
        $error("[TB] FAIL spurious_valid cyc=%0d observed out_valid=1 expected 0", cyc);
      end
      if (sb.size() != 0) begin
        e = sb.pop_front();
        nvec++;
        assert (cyc == e.cyc && out_index === e.idx && out_opaque === e.opq) else begin
          nfail++;
          $error("[TB] FAIL pixel_out observed cyc=%0d idx=%0d opq=%b expected cyc=%0d idx=%0d opq=%b",
                 cyc, out_index, out_opaque, e.cyc, e.idx, e.opq);
        end
      end
    end else begin
      nvec++;
      assert (out_valid === 1'b0 && out_index === 3'd0 && out_opaque === 1'b0 &&
              !(sb.size() != 0 && sb[0].cyc <= cyc)) else begin
        nfail++;
        $error("[TB] FAIL idle_out cyc=%0d observed valid=%b idx=%0d opq=%b pending=%0d expected valid=0 idx=0 opq=0 none due",
               cyc, out_valid, out_index, out_opaque, sb.size());
        if (sb.size() != 0 && sb[0].cyc <= cyc) void'(sb.pop_front());
      end
    end
  endtask

  task automatic applyStimulus(input logic pv, input logic fs, input int dx, input int dy);
    int         rx, ry, col;
    logic       inb;
    logic [ADDR_W-1:0] a;
    exp_t       e;
    @(negedge clk);
    cyc++;
    checkOutput();
    pix_valid   = pv;
    frame_start = fs;
    draw_x      = 10'(dx);
    draw_y      = 10'(dy);
    rx  = dx - m_hx;
    ry  = dy - m_hy;
    inb = (rx >= 0) && (rx < SPR_W) && (ry >= 0) && (ry < SPR_H);
    col = m_facing ? (SPR_W - 1 - rx) : rx;
    a   = inb ? ADDR_W'(m_frame * SPR_W * SPR_H + ry * SPR_W + col) : '0;
    pend_valid = pv;
    pend_addr  = a;
    if (pv) begin
      e.cyc = cyc + 3;
      e.idx = inb ? rom_fn(a) : 3'd0;
      e.opq = inb && (e.idx != 3'd0);
      sb.push_back(e);
    end
    if (fs) begin
      m_hx     = int'(hero_x);
      m_hy     = int'(hero_y);
      m_facing = facing_left;
      if (!running) begin
        m_hold  = 0;
        m_frame = 0;
      end else if (m_hold == FRAME_HOLD - 1) begin
        m_hold  = 0;
        m_frame = (m_frame + 1) % FRAMES;
      end else begin
        m_hold++;
      end
    end
  endtask

  task automatic modelReset();
    sb.delete();
    pend_valid = 1'b0;
    m_hx = 0; m_hy = 0; m_facing = 1'b0; m_hold = 0; m_frame = 0;
  endtask

  initial begin
    rst_n = 1'b0; frame_start = 1'b0; pix_valid = 1'b0;
    draw_x = '0; draw_y = '0; hero_x = '0; hero_y = '0;
    running = 1'b0; facing_left = 1'b0;
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 0);
    rst_n = 1'b1;
    applyStimulus(0, 0, 0, 0);

    $display("[TB] outside-box pixels and basic lookup");
    hero_x = 10'd100; hero_y = 10'd100;
    applyStimulus(0, 1, 0, 0);
    for (int i = 0; i < 10; i++) applyStimulus(1, 0, 0, 0);
    for (int i = 0; i < 4; i++) applyStimulus(0, 0, 0, 0);
    applyStimulus(1, 0, 105, 102);

    $display("[TB] mirrored lookup");
    facing_left = 1'b1;
    applyStimulus(0, 1, 0, 0);
    applyStimulus(1, 0, 105, 102);
    applyStimulus(1, 0, 100, 100);
    facing_left = 1'b0;
    applyStimulus(1, 1, 105, 102);
    applyStimulus(1, 0, 105, 102);

    $display("[TB] animation sequencing and box edges");
    running = 1'b1;
    for (int k = 1; k <= 24; k++) begin
      applyStimulus(1, 1, 131, 147);
      applyStimulus(1, 0, 100, 100);
    end
    applyStimulus(1, 0, 132, 147);
    applyStimulus(1, 0, 131, 148);
    applyStimulus(1, 0, 99, 100);
    running = 1'b0;
    for (int k = 0; k < 8; k++) applyStimulus(0, 1, 0, 0);
    running = 1'b1;
    for (int k = 0; k < 8; k++) applyStimulus(0, 1, 0, 0);
    running = 1'b0;
    applyStimulus(0, 1, 0, 0);
    applyStimulus(1, 0, 131, 147);

    $display("[TB] right screen edge");
    hero_x = 10'd620; hero_y = 10'd0;
    applyStimulus(0, 1, 0, 0);
    for (int x = 615; x < 640; x++) applyStimulus(1, 0, x, 0);
    for (int i = 0; i < 4; i++) applyStimulus(0, 0, 0, 0);

    $display("[TB] reset with pixels in flight");
    running = 1'b1;
    for (int k = 0; k < 7; k++) applyStimulus(0, 1, 0, 0);
    facing_left = 1'b1;
    applyStimulus(0, 1, 0, 0);
    applyStimulus(1, 0, 625, 10);
    applyStimulus(1, 0, 630, 20);
    #2 rst_n = 1'b0;
    modelReset();
    applyStimulus(0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) applyStimulus(0, 0, 0, 0);
    applyStimulus(1, 0, 5, 3);
    applyStimulus(1, 0, 0, 0);

    for (int i = 0; i < 6; i++) applyStimulus(0, 0, 0, 0);
    nvec++;
    assert (sb.size() == 0) else begin
      nfail++;
      $error("[TB] FAIL drain observed pending=%0d expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
